apb_rr_master: RTL
==================

Name: apb_rr_master

Overview:
- Single APB master that shares one APB bus between NREQ local requesters (config sequencer, debug port, etc.) using round-robin arbitration.
- Sequences each granted request through the APB SETUP and ACCESS phases and returns read data and error status to the requester.
- Enforces the bus wait-state budget: if the slave holds pready low for more than MAX_WAIT ACCESS cycles, the transfer is aborted and error is reported.
- Sits between the aligner's control-plane masters and the APB slave register file.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 16, APB address width.
- DW, 32, APB data width.
- MAX_WAIT, 5, maximum tolerated wait states (ACCESS cycles with pready=0) per transfer.

Ports:
- pclk  in  1  clock.
- preset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; held high until the matching done.
- req_write  in  NREQ  per-requester direction, 1=write.
- req_addr  in  NREQ*AW  per-requester address, requester i in slice [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-requester write data, same slicing.
- done  out  NREQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DW  read data, valid while done is high.
- rsp_err  out  1  pslverr or timeout, valid while done is high.
- timeout  out  1  one-cycle pulse on a wait-state abort.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  AW  APB address.
- pwdata  out  DW  APB write data.
- prdata  in  DW  APB read data.
- pready, pslverr  in  1  APB slave response.

Behaviour:
- Reset: asynchronous on preset_n low. All outputs go to 0, the FSM goes to IDLE, and the round-robin pointer goes to 0 (requester 0 has highest priority first).
- Reset mid-transfer: psel and penable drop immediately and no done is issued.
- FSM states:
  - IDLE: if any eligible req, grant the winner, latch write/addr/wdata into the APB output registers, go to SETUP. Otherwise stay in IDLE with psel=0.
  - SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS. The wait counter clears to 0.
  - ACCESS: psel=1, penable=1.
    - pready=1: capture prdata (reads only; writes return 0) and pslverr, then go to IDLE.
    - pready=0 and wait_cnt<MAX_WAIT: increment wait_cnt, stay in ACCESS.
    - pready=0 and wait_cnt==MAX_WAIT: abort. Drop psel/penable next cycle and go to IDLE with rsp_err=1 and timeout=1.
- Timing:
  - Outputs are registered. done, rsp_rdata, rsp_err and timeout are asserted in the cycle after pready (or abort) is sampled, i.e. the first IDLE cycle.
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
  - A zero-wait transfer takes 3 cycles from grant to the next possible SETUP: SETUP, ACCESS, IDLE.
- Arbitration:
  - Eligible means req[i]=1 and done[i]=0; a requester is never re-granted in its own done cycle.
  - Search starts at (last_grant+1) mod NREQ. The pointer updates only on grant.
  - Simultaneous requests are served in rotation. With all NREQ requesting, each is served once per NREQ transfers.
- Requester drops req before grant: ignored. Dropping req after grant does not cancel the transfer; done is still issued.
- req_* fields are sampled only in IDLE on the grant cycle. Later changes have no effect.

Decomposition:
- Package apb_rr_pkg:
  - state_t enum {IDLE, SETUP, ACCESS};
  - default constants for AW, DW, MAX_WAIT;
  - function onehot_to_idx.
- Sub-module rr_arbiter (NREQ): takes the eligible vector, the pointer and an advance strobe, and outputs the one-hot grant plus its index. Purely combinational, with the pointer register inside the parent.

Test Plan:
- Single write, slave pready=1 in first ACCESS: req[0], addr 0x0010, wdata 0xDEADBEEF -> psel rises cycle 1, penable cycle 2, done[0] cycle 3, rsp_err=0.
- Read with 3 wait states, prdata=0x12345678 -> ACCESS lasts 4 cycles, done[1]=1 with rsp_rdata=0x12345678, no timeout.
- Wait-state boundary:
  - pready on the 6th ACCESS cycle (5 waits) -> success;
  - pready never -> abort after 6 ACCESS cycles, timeout=1, rsp_err=1, psel=0 next cycle.
- Round-robin: NREQ=2, both req held high for 4 transfers -> grant order 0,1,0,1; each done pulses exactly once per transfer.
- Slave error: pslverr=1 with pready -> rsp_err=1, timeout=0.
- preset_n asserted during ACCESS -> psel/penable/done are 0 asynchronously. After release, the pending request re-arbitrates starting with requester 0.

Source files
------------

// File: rtl/apb_rr_pkg.sv
// Shared types and defaults for the round-robin APB master.
package apb_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned AW_DEF       = 16;
    localparam int unsigned DW_DEF       = 32;
    localparam int unsigned MAX_WAIT_DEF = 5;

    // Up to 8 requesters; callers truncate the result to their index width.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; the search starts at ptr and wraps.
module rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         eligible,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   cidx;
    int unsigned     c;

    always_comb begin
        pick = '0;
        cidx = '0;
        c    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = 32'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            cidx = IW'(c);
            if (pick == '0 && eligible[cidx]) pick[cidx] = 1'b1;
        end
    end

    assign grant     = advance ? pick : '0;
    assign grant_idx = IW'(onehot_to_idx(8'(pick)));

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters with round-robin grant and a wait-state budget.
//   state  | meaning
//   IDLE   | bus idle; completion pulses issued here; arbitrate and latch request
//   SETUP  | psel=1, penable=0 for one cycle; wait counter cleared
//   ACCESS | psel=1, penable=1 until pready or wait budget exhausted
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               timeout,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [AW-1:0]      paddr,
    output logic [DW-1:0]      pwdata,
    input  logic [DW-1:0]      prdata,
    input  logic               pready,
    input  logic               pslverr
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned WW = $clog2(MAX_WAIT + 2);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] owner_q, owner_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d, timeout_q, timeout_d;

    logic [NREQ-1:0] eligible, grant;
    logic [IW-1:0]   grant_idx;

    // A requester completing this cycle must not win again immediately.
    assign eligible = req & ~done_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .advance   (state_q == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wait_d      = wait_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        done_d      = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    owner_d   = grant;
                    ptr_d     = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                    pwrite_d  = req_write[grant_idx];
                    paddr_d   = req_addr[grant_idx*AW +: AW];
                    pwdata_d  = req_wdata[grant_idx*DW +: DW];
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    done_d      = owner_q;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                end else if (wait_q == WW'(MAX_WAIT)) begin
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    done_d    = owner_q;
                    rsp_err_d = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wait_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            done_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wait_q      <= wait_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            done_q      <= done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign done      = done_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign timeout   = timeout_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
